// File: rtl/a2d_scan_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | a2d_scan_sched : round-robin A2D scan sequencer with on-demand     |
// | pre-emption, conversion timeout and an 8-entry result file.        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module a2d_scan_sched #(
  parameter int GAP_CYCLES = 64,
  parameter int TMO_CYCLES = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  ch_mask,
  input  logic        req,
  input  logic [2:0]  req_chnnl,
  output logic        req_ack,
  output logic [11:0] od_res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_chnnl,
  output logic [11:0] rd_data,
  output logic [7:0]  fresh,
  input  logic        rd_stb,
  output logic        scan_done,
  output logic        tmo_err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    STORE     = 3'd5,
    GAP       = 3'd6
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [2:0]     cur_ch;
  logic           cur_src;     // 1 = on-demand, 0 = scan
  logic [2:0]     last_ch;
  logic [GW-1:0]  gap_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic [11:0]    file [8];

  logic [2:0]     scan_ch;
  logic           scan_hit;
  logic [2:0]     top_ch;
  logic [2:0]     arb_ch;
  logic           in_wait;
  logic           tmo_hit;
  logic           gap_end;
  logic [7:0]     fresh_nxt;

  // Next masked channel strictly after last_ch, wrapping 7->0.
  always_comb begin
    scan_hit = 1'b0;
    scan_ch  = last_ch;
    for (int i = 1; i <= 8; i++) begin
      if (!scan_hit && ch_mask[3'(last_ch + 3'(i))]) begin
        scan_hit = 1'b1;
        scan_ch  = 3'(last_ch + 3'(i));
      end
    end
  end

  always_comb begin
    top_ch = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ch_mask[i]) top_ch = 3'(i);
    end
  end

  assign arb_ch  = req ? req_chnnl : scan_ch;
  assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign tmo_hit = in_wait && (tmo_cnt == TMO_LAST);
  assign gap_end = (gap_cnt == GAP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (req || (en && (ch_mask != 8'd0))) nxt = ARB;
      ARB:       nxt = (req || (en && scan_hit)) ? START : IDLE;
      START:     nxt = WAIT_BUSY;
      WAIT_BUSY: if (!cnv_cmplt) nxt = WAIT_DONE;
                 else if (tmo_hit) nxt = GAP;
      WAIT_DONE: if (cnv_cmplt) nxt = STORE;
                 else if (tmo_hit) nxt = GAP;
      STORE:     nxt = GAP;
      GAP:       if (gap_end) nxt = ARB;
      default:   nxt = IDLE;
    endcase
  end

  // A store sets the fresh bit even when the same entry is being read-cleared.
  always_comb begin
    fresh_nxt = fresh;
    if (rd_stb) fresh_nxt[rd_chnnl] = 1'b0;
    if (state == STORE && !cur_src) fresh_nxt[cur_ch] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_ch    <= 3'd0;
      cur_src   <= 1'b0;
      last_ch   <= 3'd7;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      strt_cnv  <= 1'b0;
      chnnl     <= 3'd0;
      req_ack   <= 1'b0;
      scan_done <= 1'b0;
      tmo_err   <= 1'b0;
      od_res    <= 12'd0;
      fresh     <= 8'd0;
      for (int i = 0; i < 8; i++) file[i] <= 12'd0;
    end else begin
      req_ack   <= 1'b0;
      scan_done <= 1'b0;
      fresh     <= fresh_nxt;
      strt_cnv  <= (nxt == START) || (nxt == WAIT_BUSY);

      if (in_wait && nxt == state) tmo_cnt <= tmo_cnt + 1'b1;
      else                         tmo_cnt <= '0;

      if (state == GAP && nxt == GAP) gap_cnt <= gap_cnt + 1'b1;
      else                            gap_cnt <= '0;

      case (nxt)
        START, WAIT_BUSY, WAIT_DONE, STORE:
          chnnl <= (state == ARB) ? arb_ch : cur_ch;
        default:
          chnnl <= 3'd0;
      endcase

      if (state == ARB) begin
        cur_ch  <= arb_ch;
        cur_src <= req;
      end

      // Abort: an on-demand request stays pending; a scan skips past the channel.
      if (tmo_hit && nxt == GAP) begin
        tmo_err <= 1'b1;
        if (!cur_src) last_ch <= cur_ch;
      end

      if (state == STORE) begin
        if (cur_src) begin
          od_res  <= res;
          req_ack <= 1'b1;
        end else begin
          file[cur_ch] <= res;
          last_ch      <= cur_ch;
          scan_done    <= (ch_mask != 8'd0) && (top_ch == cur_ch);
        end
      end
    end
  end

  assign rd_data = file[rd_chnnl];

endmodule
`default_nettype wire

// File: tb/tb_a2d_scan_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_a2d_scan_sched : directed self-checking bench for a2d_scan_sched |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_a2d_scan_sched;

  localparam int GAP  = 4;
  localparam int TMO  = 16;
  localparam int CONV = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  ch_mask;
  logic        req;
  logic [2:0]  req_chnnl;
  logic        req_ack;
  logic [11:0] od_res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt = 1'b1;
  logic [11:0] res = 12'd0;
  logic [2:0]  rd_chnnl;
  logic [11:0] rd_data;
  logic [7:0]  fresh;
  logic        rd_stb;
  logic        scan_done;
  logic        tmo_err;

  int n_chk  = 0;
  int n_fail = 0;
  int sd_cnt = 0;

  // A2D interface model: 2-flop start filter, fixed conversion time.
  logic        s1 = 1'b0;
  logic        s2 = 1'b0;
  int          busy = 0;
  logic [2:0]  conv_ch = 3'd0;
  logic        a2d_stuck = 1'b0;
  logic [11:0] res_ofs = 12'd0;

  a2d_scan_sched #(.GAP_CYCLES(GAP), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_mask(ch_mask), .req(req),
    .req_chnnl(req_chnnl), .req_ack(req_ack), .od_res(od_res),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .res(res),
    .rd_chnnl(rd_chnnl), .rd_data(rd_data), .fresh(fresh), .rd_stb(rd_stb),
    .scan_done(scan_done), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    s1 <= strt_cnv;
    s2 <= s1;
    if (cnv_cmplt) begin
      if (s2 && !a2d_stuck) begin
        cnv_cmplt <= 1'b0;
        busy      <= CONV;
        conv_ch   <= chnnl;
      end
    end else if (busy == 0) begin
      cnv_cmplt <= 1'b1;
      res       <= 12'h100 + {9'd0, conv_ch} + res_ofs;
    end else begin
      busy <= busy - 1;
    end
  end

  always @(posedge clk) if (scan_done === 1'b1) sd_cnt <= sd_cnt + 1;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int max, output bit found, output logic [2:0] ch, output int lat);
    found = 1'b0;
    ch    = 3'd0;
    lat   = 0;
    for (int i = 0; i < max && strt_cnv === 1'b1; i++) step();
    for (int i = 0; i < max; i++) begin
      step();
      lat = i + 1;
      if (strt_cnv === 1'b1) begin
        found = 1'b1;
        ch    = chnnl;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (req_ack === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cmplt(input logic val, input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (cnv_cmplt === val) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_sd(input int max, output bit found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (scan_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         f;
    logic [2:0] ch;
    int         lat;
    int         hi;

    rst = 1'b1; en = 1'b0; ch_mask = 8'd0; req = 1'b0; req_chnnl = 3'd0;
    rd_chnnl = 3'd0; rd_stb = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_strt",  32'(strt_cnv),  0);
    chk("rst_chnnl", 32'(chnnl),     0);
    chk("rst_ack",   32'(req_ack),   0);
    chk("rst_sd",    32'(scan_done), 0);
    chk("rst_tmo",   32'(tmo_err),   0);
    chk("rst_odres", 32'(od_res),    0);
    chk("rst_fresh", 32'(fresh),     0);
    chk("rst_rd",    32'(rd_data),   0);

    // Scan mask 0x05: first start two edges after release, on ch 0
    en = 1'b1; ch_mask = 8'h05;
    step();
    rst = 1'b0;
    step();
    chk("lat_e1_strt", 32'(strt_cnv), 0);
    step();
    chk("lat_e2_strt", 32'(strt_cnv), 1);
    chk("scan1_ch", 32'(chnnl), 0);
    wait_start(200, f, ch, lat);
    chk("scan2_found", 32'(f), 1);
    chk("scan2_ch", 32'(ch), 2);
    wait_start(200, f, ch, lat);
    chk("scan3_ch", 32'(ch), 0);
    chk("scan_sd_cnt", 32'(sd_cnt), 1);
    chk("scan_fresh", 32'(fresh), 32'h05);
    rd_chnnl = 3'd0; #1;
    chk("file0", 32'(rd_data), 32'h100);
    rd_chnnl = 3'd2; #1;
    chk("file2", 32'(rd_data), 32'h102);

    // On-demand pre-emption while ch 0 converts
    req = 1'b1; req_chnnl = 3'd5;
    wait_start(200, f, ch, lat);
    chk("od5_ch", 32'(ch), 5);
    wait_ack(200, f);
    chk("od5_ack", 32'(f), 1);
    chk("od5_res", 32'(od_res), 32'h105);
    req = 1'b0;
    step();
    chk("od5_ack_pulse", 32'(req_ack), 0);
    wait_start(200, f, ch, lat);
    chk("resume_ch", 32'(ch), 2);

    // Empty mask: no scan starts, but an on-demand request still runs
    ch_mask = 8'h00;
    wait_start(40, f, ch, lat);
    chk("idle_nostart", 32'(f), 0);
    chk("idle_chnnl", 32'(chnnl), 0);
    req = 1'b1; req_chnnl = 3'd3;
    wait_start(200, f, ch, lat);
    chk("od3_lat", 32'(lat), 2);
    chk("od3_ch", 32'(ch), 3);
    wait_ack(200, f);
    chk("od3_ack", 32'(f), 1);
    chk("od3_res", 32'(od_res), 32'h103);
    req = 1'b0;
    wait_start(30, f, ch, lat);
    chk("od3_back_idle", 32'(f), 0);

    // Timeout: A2D never drops cnv_cmplt
    chk("pre_tmo", 32'(tmo_err), 0);
    a2d_stuck = 1'b1; ch_mask = 8'h05;
    wait_start(200, f, ch, lat);
    chk("tmo_lat", 32'(lat), 2);
    chk("tmo_ch", 32'(ch), 0);
    hi = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (strt_cnv === 1'b1) hi++;
      else break;
    end
    chk("tmo_strt_len", 32'(hi), 17);
    chk("tmo_err_set", 32'(tmo_err), 1);
    wait_start(200, f, ch, lat);
    chk("tmo_next_lat", 32'(lat), 5);
    chk("tmo_next_ch", 32'(ch), 2);
    a2d_stuck = 1'b0;
    wait_start(200, f, ch, lat);
    chk("tmo_recover_ch", 32'(ch), 0);
    chk("tmo_err_sticky", 32'(tmo_err), 1);

    // rd_stb clears, then collides with a store to the same entry
    rd_chnnl = 3'd0; rd_stb = 1'b1;
    step();
    rd_stb = 1'b0;
    chk("rdstb_clr0", 32'(fresh[0]), 0);
    rd_chnnl = 3'd2; rd_stb = 1'b1;
    step();
    rd_stb = 1'b0;
    chk("rdstb_clr2", 32'(fresh[2]), 0);
    res_ofs = 12'h200;
    wait_start(200, f, ch, lat);
    chk("coll_ch", 32'(ch), 2);
    ch_mask = 8'h06;
    wait_cmplt(1'b0, 50, f);
    chk("coll_busy", 32'(f), 1);
    wait_cmplt(1'b1, 50, f);
    chk("coll_done", 32'(f), 1);
    step();
    rd_chnnl = 3'd2; rd_stb = 1'b1; #1;
    chk("coll_rd_old", 32'(rd_data), 32'h102);
    step();
    rd_stb = 1'b0;
    chk("coll_fresh2", 32'(fresh[2]), 1);
    chk("coll_rd_new", 32'(rd_data), 32'h302);
    chk("coll_sd", 32'(scan_done), 1);

    // Asynchronous reset during WAIT_DONE on ch 1
    wait_start(200, f, ch, lat);
    chk("rst_pre_ch", 32'(ch), 1);
    wait_cmplt(1'b0, 50, f);
    step();
    chk("rst_pre_chnnl", 32'(chnnl), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_strt",  32'(strt_cnv),  0);
    chk("arst_chnnl", 32'(chnnl),     0);
    chk("arst_ack",   32'(req_ack),   0);
    chk("arst_sd",    32'(scan_done), 0);
    chk("arst_tmo",   32'(tmo_err),   0);
    chk("arst_odres", 32'(od_res),    0);
    chk("arst_fresh", 32'(fresh),     0);
    chk("arst_rd",    32'(rd_data),   0);
    ch_mask = 8'h80;
    repeat (10) step();
    rst = 1'b0;
    wait_start(200, f, ch, lat);
    chk("post_rst_lat", 32'(lat), 2);
    chk("post_rst_ch", 32'(ch), 7);
    wait_sd(200, f);
    chk("post_rst_sd", 32'(f), 1);
    rd_chnnl = 3'd7; #1;
    chk("post_rst_file7", 32'(rd_data), 32'h307);
    chk("post_rst_fresh", 32'(fresh), 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/a2d_scan_sched.md
# a2d_scan_sched

Sequencer and arbiter for the SPI A2D interface block. It drives `strt_cnv`/`chnnl`, waits for `cnv_cmplt`, and captures `res`. It round-robins through a masked set of the eight A2D channels and lets one on-demand requester pre-empt the scan between conversions. Results go into an 8-entry result file that downstream control logic reads by channel number.

## Interface
Parameters:
- `GAP_CYCLES`, 64: idle clk cycles between the end of one conversion and the next start (min 1).
- `TMO_CYCLES`, 4095: max clk cycles for any single wait state before abort.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  periodic scan enable.
- `ch_mask`  in  8  channels included in scan; bit i = channel i.
- `req`  in  1  on-demand conversion request (level; held until `req_ack`).
- `req_chnnl`  in  3  channel for on-demand request.
- `req_ack`  out  1  one-cycle pulse; on-demand result valid on `od_res` this cycle.
- `od_res`  out  12  on-demand result, held until next `req_ack`.
- `strt_cnv`  out  1  to A2D interface; start conversion.
- `chnnl`  out  3  to A2D interface; channel being converted.
- `cnv_cmplt`  in  1  from A2D interface; high when idle/complete.
- `res`  in  12  from A2D interface; conversion result.
- `rd_chnnl`  in  3  result-file read address.
- `rd_data`  out  12  result file entry `rd_chnnl` (combinational read).
- `fresh`  out  8  bit i set when entry i is written; cleared when read (`rd_stb`).
- `rd_stb`  in  1  clears `fresh[rd_chnnl]` on this cycle.
- `scan_done`  out  1  one-cycle pulse on completion of a full mask pass.
- `tmo_err`  out  1  sticky; set on any timeout; cleared only by `rst`.

## Operation
- States: IDLE, ARB, START, WAIT_BUSY, WAIT_DONE, STORE, GAP.
- IDLE: go to ARB when `req`, or when `en` and `ch_mask != 0`.
- ARB (1 cycle): `req` wins; otherwise the scan channel is the next set bit of `ch_mask` strictly after `last_ch`, wrapping 7->0. Latch the chosen channel and the source (OD or SCAN) into `cur_ch` and `cur_src`. If nothing qualifies, return to IDLE.
- START: `strt_cnv`=1, `chnnl`=`cur_ch`. Next state is WAIT_BUSY.
- WAIT_BUSY: hold `strt_cnv`=1 until `cnv_cmplt`=0. Holding guarantees the interface's 2-flop start filter sees it. Then go to WAIT_DONE.
- WAIT_DONE: `strt_cnv`=0. Wait for `cnv_cmplt`=1, then go to STORE.
- STORE (1 cycle), for OD: `od_res`<=`res` and pulse `req_ack`.
- STORE (1 cycle), for SCAN: `file[cur_ch]`<=`res`, set `fresh[cur_ch]`, `last_ch`<=`cur_ch`. Pulse `scan_done` if `cur_ch` is the highest set bit of current `ch_mask`.
- After STORE, go to GAP.
- GAP: count `GAP_CYCLES` cycles, then go to ARB.
- `chnnl` holds `cur_ch` in every state from START through STORE. It is 0 in IDLE.
- Timeout: a counter runs in WAIT_BUSY and WAIT_DONE and resets on each state entry. On reaching `TMO_CYCLES`:
  - set `tmo_err` and drop `strt_cnv`;
  - the OD request is not acked and is retried at the next ARB;
  - scan advances `last_ch` past `cur_ch`;
  - go to GAP with no store.
- `en` deasserting takes effect only at ARB. A conversion in flight always completes.
- `ch_mask` is sampled only in ARB and STORE. Changes mid-conversion do not abort.
- `rd_stb` and a STORE to the same entry in the same cycle: `fresh` ends set.

## Timing
- Reset values:
  - State IDLE; `last_ch`=7, so the first scan channel is the lowest set bit.
  - `strt_cnv`=0, `chnnl`=0, `req_ack`=0, `scan_done`=0, `tmo_err`=0.
  - `od_res`=0, all file entries=0, `fresh`=0.
- Reset mid-conversion drops `strt_cnv` asynchronously. The A2D interface is left to finish on its own.
- IDLE->START takes 2 cycles (IDLE->ARB->START). `strt_cnv` rises on the 2nd clk edge after `req` or `en` is seen.
- `strt_cnv` is high for at least 1 cycle, and for exactly (cycles until `cnv_cmplt` falls) + 1.
- `req_ack` and `od_res` update one cycle after `cnv_cmplt` is seen high in WAIT_DONE.
- Minimum start-to-start spacing = conversion time + `GAP_CYCLES` + 3.
- All outputs are registered except `rd_data`.

## Test plan
- Reset, `en`=1, `ch_mask`=8'h05, model A2D returns 12'h100+chnnl -> conversions on ch 0,2,0,2...; file[0]=12'h100, file[2]=12'h102; `scan_done` pulses after each ch 2 store; `fresh`=8'h05.
- Scan running on ch 0, raise `req` with `req_chnnl`=5 -> ch 0 completes, next start on ch 5, `req_ack` pulses with `od_res`=12'h105, scan resumes at ch 2.
- Model never lowers `cnv_cmplt`, `TMO_CYCLES`=16 -> `strt_cnv` drops after 16 cycles in WAIT_BUSY, `tmo_err`=1 sticky, next channel attempted after the gap.
- `ch_mask`=0, `en`=1, `req`=0 -> stays IDLE, `strt_cnv` never rises; then `req`=1 with `req_chnnl`=3 -> single conversion, `req_ack`, back to IDLE.
- Assert `rst` while in WAIT_DONE -> all outputs return to reset values same cycle; after release with `ch_mask`=8'h80, first conversion is on ch 7.
- `rd_stb` with `rd_chnnl`=2 in the same cycle as STORE to ch 2 -> `fresh[2]`=1 and `rd_data` shows the new value next cycle.
